// File: rtl/jt51_pm_depth.sv
// PM depth generator: LFO PM sample x PMD via shift-add multiplier, then PMS scaling per slot.
// Define JT51_PM_FASTMUL_EN to replace the 7-step serial multiplier with a one-cycle product.
module jt51_pm_depth (
  input  logic       rst,
  input  logic       clk,
  input  logic       cen,
  input  logic [6:0] lfo_pm,
  input  logic       lfo_pm_sign,
  input  logic       lfo_upd,
  input  logic [6:0] pmd,
  input  logic [2:0] pms,
  output logic [8:0] mod_O,
  output logic       add_O,
  output logic       busy,
  output logic       mul_done
);

  logic [6:0]  a_q, a_d, b_q, b_d, depth_q, depth_d;
  logic        s_q, s_d, sign_q, sign_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [8:0]  mod_q, mod_d;
  logic        add_q, add_d;
  logic [13:0] product;
  logic        commit;
  logic [8:0]  depth_ext;

`ifdef JT51_PM_FASTMUL_EN
  assign product = {7'd0, a_q} * {7'd0, b_q};
  assign commit  = busy_q;
`else
  logic [2:0]  step_q, step_d;
  logic [13:0] acc_q, acc_d, partial;

  // product is the accumulator after the current step has been added
  always_comb begin
    partial = 14'd0;
    if (b_q[step_q]) partial = {7'd0, a_q} << step_q;
  end
  assign product = acc_q + partial;
  assign commit  = busy_q && (step_q == 3'd6);

  always_comb begin
    step_d = step_q;
    acc_d  = acc_q;
    if (cen) begin
      if (lfo_upd) begin
        step_d = 3'd0;
        acc_d  = 14'd0;
      end else if (busy_q) begin
        step_d = commit ? 3'd0 : step_q + 3'd1;
        acc_d  = product;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= 3'd0;
      acc_q  <= 14'd0;
    end else begin
      step_q <= step_d;
      acc_q  <= acc_d;
    end
  end
`endif

  assign depth_ext = {2'b00, depth_q};

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    busy_d  = busy_q;
    depth_d = depth_q;
    sign_d  = sign_q;
    done_d  = 1'b0;
    mod_d   = mod_q;
    add_d   = add_q;
    if (cen) begin
      // a new sample always wins over a pending commit
      if (lfo_upd) begin
        a_d    = lfo_pm;
        b_d    = pmd;
        s_d    = lfo_pm_sign;
        busy_d = 1'b1;
      end else if (commit) begin
        depth_d = product[13:7];
        sign_d  = s_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      case (pms)
        3'd0:    mod_d = 9'd0;
        3'd6:    mod_d = depth_ext << 1;
        3'd7:    mod_d = depth_ext << 2;
        default: mod_d = depth_ext >> (3'd6 - pms);
      endcase
      add_d = (mod_d == 9'd0) ? 1'b1 : ~sign_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= 7'd0;
      b_q     <= 7'd0;
      s_q     <= 1'b0;
      busy_q  <= 1'b0;
      depth_q <= 7'd0;
      sign_q  <= 1'b0;
      done_q  <= 1'b0;
      mod_q   <= 9'd0;
      add_q   <= 1'b1;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      depth_q <= depth_d;
      sign_q  <= sign_d;
      done_q  <= done_d;
      mod_q   <= mod_d;
      add_q   <= add_d;
    end
  end

  assign mod_O    = mod_q;
  assign add_O    = add_q;
  assign busy     = busy_q;
  assign mul_done = done_q;

endmodule

// File: tb/tb_jt51_pm_depth.sv
// Directed self-checking bench for jt51_pm_depth; follows JT51_PM_FASTMUL_EN for multiply latency.
module tb_jt51_pm_depth;

  logic       rst, clk, cen;
  logic [6:0] lfo_pm, pmd;
  logic       lfo_pm_sign, lfo_upd;
  logic [2:0] pms;
  logic [8:0] mod_O;
  logic       add_O, busy, mul_done;

  int checks = 0;
  int errors = 0;

`ifdef JT51_PM_FASTMUL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 7;
`endif
  localparam int R = (LAT >= 3) ? 3 : LAT;

  jt51_pm_depth dut (
    .rst(rst), .clk(clk), .cen(cen), .lfo_pm(lfo_pm), .lfo_pm_sign(lfo_pm_sign),
    .lfo_upd(lfo_upd), .pmd(pmd), .pms(pms), .mod_O(mod_O), .add_O(add_O),
    .busy(busy), .mul_done(mul_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input logic [2:0] p);
    cen = 1'b1;
    pms = p;
    cyc();
    $display("[%0t] slot pms=%0d mod_O=%0d add_O=%0d", $time, p, mod_O, add_O);
  endtask

  task automatic test_reset();
    rst = 1'b1; cen = 1'b1; lfo_pm = 7'd0; pmd = 7'd0; lfo_pm_sign = 1'b0;
    lfo_upd = 1'b0; pms = 3'd0;
    repeat (2) cyc();
    checks++;
    if (mod_O !== 9'd0 || add_O !== 1'b1 || busy !== 1'b0 || mul_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state mod_O=%0d add_O=%b busy=%b mul_done=%b expected 0/1/0/0",
               mod_O, add_O, busy, mul_done);
    end
    rst = 1'b0;
    slot(3'd7);
    checks++;
    if (mod_O !== 9'd0 || add_O !== 1'b1) begin
      errors++;
      $display("FAIL reset_depth mod_O=%0d add_O=%b expected 0/1", mod_O, add_O);
    end
  endtask

  task automatic test_full_scale();
    cen = 1'b1; lfo_pm = 7'd127; pmd = 7'd127; lfo_pm_sign = 1'b0; lfo_upd = 1'b1;
    cyc();  // E0
    lfo_upd = 1'b0; lfo_pm = 7'd0; pmd = 7'd0;
    checks++;
    if (busy !== 1'b1 || mul_done !== 1'b0) begin
      errors++;
      $display("FAIL fs_start busy=%b mul_done=%b expected 1/0", busy, mul_done);
    end
    for (int k = 1; k <= LAT; k++) begin
      cyc();
      if (k < LAT) begin
        checks++;
        if (busy !== 1'b1 || mul_done !== 1'b0) begin
          errors++;
          $display("FAIL fs_step%0d busy=%b mul_done=%b expected 1/0", k, busy, mul_done);
        end
      end
    end
    $display("[%0t] full-scale commit mul_done=%b busy=%b", $time, mul_done, busy);
    checks++;
    if (mul_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fs_commit mul_done=%b busy=%b expected 1/0", mul_done, busy);
    end
    slot(3'd7);
    checks++;
    if (mod_O !== 9'd504 || add_O !== 1'b1 || mul_done !== 1'b0) begin
      errors++;
      $display("FAIL fs_pms7 mod_O=%0d add_O=%b mul_done=%b expected 504/1/0", mod_O, add_O, mul_done);
    end
    slot(3'd1);
    checks++;
    if (mod_O !== 9'd3) begin
      errors++;
      $display("FAIL fs_pms1 mod_O=%0d expected 3", mod_O);
    end
    slot(3'd6);
    checks++;
    if (mod_O !== 9'd252) begin
      errors++;
      $display("FAIL fs_pms6 mod_O=%0d expected 252", mod_O);
    end
  endtask

  task automatic test_negative();
    cen = 1'b1; lfo_pm = 7'd100; pmd = 7'd64; lfo_pm_sign = 1'b1; lfo_upd = 1'b1;
    cyc();
    lfo_upd = 1'b0;
    repeat (LAT) cyc();
    checks++;
    if (mul_done !== 1'b1) begin
      errors++;
      $display("FAIL neg_commit mul_done=%b expected 1", mul_done);
    end
    slot(3'd4);
    checks++;
    if (mod_O !== 9'd12 || add_O !== 1'b0) begin
      errors++;
      $display("FAIL neg_pms4 mod_O=%0d add_O=%b expected 12/0", mod_O, add_O);
    end
    slot(3'd0);
    checks++;
    if (mod_O !== 9'd0 || add_O !== 1'b1) begin
      errors++;
      $display("FAIL neg_pms0 mod_O=%0d add_O=%b expected 0/1", mod_O, add_O);
    end
  endtask

  task automatic test_restart();
    cen = 1'b1; pms = 3'd5;
    lfo_pm = 7'd127; pmd = 7'd127; lfo_pm_sign = 1'b1; lfo_upd = 1'b1;
    cyc();  // E0
    lfo_upd = 1'b0;
    for (int k = 1; k < R; k++) begin
      cyc();
      checks++;
      if (mul_done !== 1'b0) begin
        errors++;
        $display("FAIL rs_early%0d mul_done=%b expected 0", k, mul_done);
      end
    end
    lfo_pm = 7'd64; pmd = 7'd64; lfo_pm_sign = 1'b0; lfo_upd = 1'b1;
    cyc();  // restart edge
    lfo_upd = 1'b0;
    checks++;
    if (mul_done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rs_restart mul_done=%b busy=%b expected 0/1", mul_done, busy);
    end
    for (int k = 1; k <= LAT; k++) begin
      cyc();
      if (k < LAT) begin
        checks++;
        if (mul_done !== 1'b0) begin
          errors++;
          $display("FAIL rs_wait%0d mul_done=%b expected 0", k, mul_done);
        end
      end
    end
    $display("[%0t] restart commit mul_done=%b", $time, mul_done);
    checks++;
    if (mul_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rs_commit mul_done=%b busy=%b expected 1/0", mul_done, busy);
    end
    slot(3'd5);
    checks++;
    if (mod_O !== 9'd16 || add_O !== 1'b1) begin
      errors++;
      $display("FAIL rs_pms5 mod_O=%0d add_O=%b expected 16/1", mod_O, add_O);
    end
  endtask

  task automatic test_cen_gating();
    slot(3'd7);  // depth 32 -> 128
    checks++;
    if (mod_O !== 9'd128) begin
      errors++;
      $display("FAIL cg_pre mod_O=%0d expected 128", mod_O);
    end
    cen = 1'b1; lfo_pm = 7'd64; pmd = 7'd127; lfo_pm_sign = 1'b0; lfo_upd = 1'b1;
    cyc();  // E0
    lfo_upd = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      cen = 1'b0; pms = 3'd3;
      for (int j = 0; j < 3; j++) begin
        cyc();
        checks++;
        if (busy !== 1'b1 || mul_done !== 1'b0 || mod_O !== 9'd128) begin
          errors++;
          $display("FAIL cg_idle%0d_%0d busy=%b mul_done=%b mod_O=%0d expected 1/0/128",
                   k, j, busy, mul_done, mod_O);
        end
      end
      cen = 1'b1; pms = 3'd7;
      cyc();
      if (k < LAT) begin
        checks++;
        if (mul_done !== 1'b0) begin
          errors++;
          $display("FAIL cg_edge%0d mul_done=%b expected 0", k, mul_done);
        end
      end
    end
    checks++;
    if (mul_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cg_commit mul_done=%b busy=%b expected 1/0", mul_done, busy);
    end
    cen = 1'b0;
    cyc();
    $display("[%0t] cen-gated commit done, mul_done now %b", $time, mul_done);
    checks++;
    if (mul_done !== 1'b0 || mod_O !== 9'd128) begin
      errors++;
      $display("FAIL cg_pulse mul_done=%b mod_O=%0d expected 0/128", mul_done, mod_O);
    end
    slot(3'd7);
    checks++;
    if (mod_O !== 9'd252) begin
      errors++;
      $display("FAIL cg_post mod_O=%0d expected 252", mod_O);
    end
  endtask

  task automatic test_reset_mid_op();
    cen = 1'b1; lfo_pm = 7'd127; pmd = 7'd127; lfo_pm_sign = 1'b1; lfo_upd = 1'b1;
    cyc();
    lfo_upd = 1'b0;
    cen = 1'b0;
    cyc();
    cen = 1'b1;
    cyc();
    #2 rst = 1'b1;
    #1;
    $display("[%0t] async reset mid-op mod_O=%0d add_O=%b busy=%b", $time, mod_O, add_O, busy);
    checks++;
    if (mod_O !== 9'd0 || add_O !== 1'b1 || busy !== 1'b0 || mul_done !== 1'b0) begin
      errors++;
      $display("FAIL rm_async mod_O=%0d add_O=%b busy=%b mul_done=%b expected 0/1/0/0",
               mod_O, add_O, busy, mul_done);
    end
    repeat (2) cyc();
    rst = 1'b0;
    for (int k = 0; k < LAT + 1; k++) begin
      cyc();
      checks++;
      if (busy !== 1'b0 || mul_done !== 1'b0) begin
        errors++;
        $display("FAIL rm_idle%0d busy=%b mul_done=%b expected 0/0", k, busy, mul_done);
      end
    end
    slot(3'd7);
    checks++;
    if (mod_O !== 9'd0 || add_O !== 1'b1) begin
      errors++;
      $display("FAIL rm_depth mod_O=%0d add_O=%b expected 0/1", mod_O, add_O);
    end
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_negative();
    test_restart();
    test_cen_gating();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
